// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolver
//  Description : Resolves conditional branches (B / BR) from the Z/V/N flag
//                register, forwarding same-cycle flag writes. Tracks in-flight
//                flag writers so a branch waits until its flags are final.
//                Produces a registered taken/target decision plus a flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int PEND_W = 2,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_ccc,
    input  logic              br_reg,
    input  logic [ADDR_W-1:0] br_pc_plus2,
    input  logic [8:0]        br_offset,
    input  logic [ADDR_W-1:0] br_rs_data,
    input  logic              Z,
    input  logic              V,
    input  logic              N,
    input  logic              Z_en,
    input  logic              Z_set,
    input  logic              V_en,
    input  logic              V_set,
    input  logic              N_en,
    input  logic              N_set,
    input  logic              fs_issue,
    output logic              fs_full,
    output logic              res_valid,
    output logic              res_taken,
    output logic [ADDR_W-1:0] res_target,
    output logic              flush
);

    localparam logic [PEND_W-1:0] c_pend_max  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] c_pend_zero = '0;
    localparam logic [PEND_W-1:0] c_pend_one  = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        c_uncond    = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [2:0]         ccc_q, ccc_d;
    logic [ADDR_W-1:0]  target_q, target_d;
    logic [ADDR_W-1:0]  pc2_q, pc2_d;
    logic               res_valid_q, res_valid_d;
    logic               res_taken_q, res_taken_d;
    logic [ADDR_W-1:0]  res_target_q, res_target_d;
    logic               flush_q, flush_d;

    logic               w_fw;
    logic               w_zf, w_vf, w_nf;
    logic               w_fin;
    logic [ADDR_W-1:0]  w_off_ext;
    logic [ADDR_W-1:0]  w_br_target;

    // Condition-code evaluation against a set of effective flags.
    function automatic logic cond_true(input logic [2:0] ccc,
                                       input logic zf, input logic vf, input logic nf);
        logic r;
        case (ccc)
            3'b000:  r = ~zf;
            3'b001:  r = zf;
            3'b010:  r = ~zf & ~nf;
            3'b011:  r = nf;
            3'b100:  r = zf | (~zf & ~nf);
            3'b101:  r = nf | zf;
            3'b110:  r = vf;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Flag forwarding, finality and incoming-branch target computation.
    always_comb begin
        w_fw        = Z_en | V_en | N_en;
        w_zf        = Z_en ? Z_set : Z;
        w_vf        = V_en ? V_set : V;
        w_nf        = N_en ? N_set : N;
        // The last outstanding writer retiring this cycle makes flags final,
        // unless a new writer enters at the same time.
        w_fin       = (pend_q == c_pend_zero) |
                      ((pend_q == c_pend_one) & w_fw & ~fs_issue);
        w_off_ext   = {{(ADDR_W-9){br_offset[8]}}, br_offset};
        w_br_target = br_reg ? br_rs_data
                             : br_pc_plus2 + {w_off_ext[ADDR_W-2:0], 1'b0};
    end

    // Scoreboard of in-flight flag writers, saturating at both ends.
    always_comb begin
        pend_d = pend_q;
        if (fs_issue & ~w_fw & (pend_q != c_pend_max))
            pend_d = pend_q + c_pend_one;
        else if (w_fw & ~fs_issue & (pend_q != c_pend_zero))
            pend_d = pend_q - c_pend_one;
    end

    // Branch FSM: resolve immediately when flags are final, otherwise wait.
    always_comb begin
        state_d      = state_q;
        ccc_d        = ccc_q;
        target_d     = target_q;
        pc2_d        = pc2_q;
        res_valid_d  = 1'b0;
        res_taken_d  = res_taken_q;
        res_target_d = res_target_q;
        flush_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    ccc_d    = br_ccc;
                    target_d = w_br_target;
                    pc2_d    = br_pc_plus2;
                    if (w_fin | (br_ccc == c_uncond)) begin
                        res_valid_d  = 1'b1;
                        res_taken_d  = cond_true(br_ccc, w_zf, w_vf, w_nf);
                        res_target_d = res_taken_d ? w_br_target : br_pc_plus2;
                        flush_d      = res_taken_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (w_fin | (ccc_q == c_uncond)) begin
                    res_valid_d  = 1'b1;
                    res_taken_d  = cond_true(ccc_q, w_zf, w_vf, w_nf);
                    res_target_d = res_taken_d ? target_q : pc2_q;
                    flush_d      = res_taken_d;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pend_q       <= c_pend_zero;
            ccc_q        <= 3'b000;
            target_q     <= '0;
            pc2_q        <= '0;
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            ccc_q        <= ccc_d;
            target_q     <= target_d;
            pc2_q        <= pc2_d;
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            res_target_q <= res_target_d;
            flush_q      <= flush_d;
        end
    end

    assign br_ready   = (state_q == S_IDLE);
    assign fs_full    = (pend_q == c_pend_max);
    assign res_valid  = res_valid_q;
    assign res_taken  = res_taken_q;
    assign res_target = res_target_q;
    assign flush      = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolver
//  Description : Self-checking bench for branch_resolver with a result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

    localparam int PEND_W = 2;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              br_valid, br_ready, br_reg;
    logic [2:0]        br_ccc;
    logic [ADDR_W-1:0] br_pc_plus2, br_rs_data;
    logic [8:0]        br_offset;
    logic              Z, V, N, Z_en, Z_set, V_en, V_set, N_en, N_set;
    logic              fs_issue, fs_full;
    logic              res_valid, res_taken, flush;
    logic [ADDR_W-1:0] res_target;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic              taken;
        logic [ADDR_W-1:0] target;
    } exp_t;
    exp_t exp_q[$];

    branch_resolver #(.PEND_W(PEND_W), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst(rst),
        .br_valid(br_valid), .br_ready(br_ready), .br_ccc(br_ccc), .br_reg(br_reg),
        .br_pc_plus2(br_pc_plus2), .br_offset(br_offset), .br_rs_data(br_rs_data),
        .Z(Z), .V(V), .N(N),
        .Z_en(Z_en), .Z_set(Z_set), .V_en(V_en), .V_set(V_set), .N_en(N_en), .N_set(N_set),
        .fs_issue(fs_issue), .fs_full(fs_full),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_cond(input logic [2:0] c, input logic zf, input logic vf, input logic nf);
        case (c)
            3'd0: return !zf;
            3'd1: return zf;
            3'd2: return !zf && !nf;
            3'd3: return nf;
            3'd4: return zf || (!zf && !nf);
            3'd5: return nf || zf;
            3'd6: return vf;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] model_tgt(input logic r, input logic [ADDR_W-1:0] pc2,
                                                    input logic [8:0] off, input logic [ADDR_W-1:0] rs);
        logic signed [ADDR_W-1:0] so;
        so = {{(ADDR_W-9){off[8]}}, off};
        return r ? rs : pc2 + ADDR_W'(so * 2);
    endfunction

    // Scoreboard: every decision pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_res_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("res_taken", 32'(res_taken), 32'(e.taken));
                check_val("res_target", 32'(res_target), 32'(e.target));
                check_val("flush", 32'(flush), 32'(e.taken));
            end
        end else if (flush) begin
            check_val("flush_without_valid", 32'(flush), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags_wr();
        Z_en = 0; Z_set = 0; V_en = 0; V_set = 0; N_en = 0; N_set = 0;
    endtask

    // Drive a branch for one cycle; exp_push queues the expected decision.
    task automatic drive_branch(input logic [2:0] c, input logic r, input logic [ADDR_W-1:0] pc2,
                                input logic [8:0] off, input logic [ADDR_W-1:0] rs,
                                input logic exp_push, input logic etaken);
        exp_t e;
        br_valid = 1; br_ccc = c; br_reg = r; br_pc_plus2 = pc2; br_offset = off; br_rs_data = rs;
        if (exp_push) begin
            e.taken  = etaken;
            e.target = etaken ? model_tgt(r, pc2, off, rs) : pc2;
            exp_q.push_back(e);
        end
        tick();
        br_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; br_valid = 0; br_ccc = 0; br_reg = 0; br_pc_plus2 = 0; br_offset = 0; br_rs_data = 0;
        Z = 0; V = 0; N = 0; fs_issue = 0;
        clear_flags_wr();
        tick(); tick();
        rst = 0;
        @(negedge clk);
        check_val("rst_res_valid", 32'(res_valid), 32'd0);
        check_val("rst_res_taken", 32'(res_taken), 32'd0);
        check_val("rst_res_target", 32'(res_target), 32'd0);
        check_val("rst_flush", 32'(flush), 32'd0);
        check_val("rst_br_ready", 32'(br_ready), 32'd1);
        check_val("rst_fs_full", 32'(fs_full), 32'd0);

        // Unconditional B, latency 1.
        drive_branch(3'b111, 0, 16'h0010, 9'd4, 16'h0, 1, 1);
        check_val("uncond_latency", 32'(res_valid), 32'd1);
        check_val("uncond_target_direct", 32'(res_target), 32'h0018);

        // BR EQ / NE with Z=1, back to back.
        Z = 1;
        drive_branch(3'b001, 1, 16'h0200, 9'd0, 16'h1234, 1, 1);
        drive_branch(3'b000, 1, 16'h0200, 9'd0, 16'h1234, 1, 0);
        check_val("b2b_valid", 32'(res_valid), 32'd1);
        tick();
        check_val("b2b_done", 32'(res_valid), 32'd0);

        // All condition codes with stored and forwarded flags, pend=0.
        for (int i = 0; i < 32; i++) begin
            logic [2:0] c;
            logic zf, vf, nf, r;
            logic [ADDR_W-1:0] pc2, rs;
            logic [8:0] off;
            c = 3'(i % 8);
            Z = 1'($urandom); V = 1'($urandom); N = 1'($urandom);
            Z_en = 1'($urandom); Z_set = 1'($urandom);
            V_en = 1'($urandom); V_set = 1'($urandom);
            N_en = 1'($urandom); N_set = 1'($urandom);
            zf = Z_en ? Z_set : Z;
            vf = V_en ? V_set : V;
            nf = N_en ? N_set : N;
            r = 1'($urandom); pc2 = 16'($urandom); rs = 16'($urandom); off = 9'($urandom);
            drive_branch(c, r, pc2, off, rs, 1, model_cond(c, zf, vf, nf));
        end
        clear_flags_wr();
        Z = 0; V = 0; N = 0;
        tick();

        // One writer in flight: LT branch waits for forwarded N.
        fs_issue = 1; tick(); fs_issue = 0;
        drive_branch(3'b011, 0, 16'h0300, 9'd8, 16'h0, 1, 1);
        check_val("wait_br_ready", 32'(br_ready), 32'd0);
        check_val("wait_no_valid", 32'(res_valid), 32'd0);
        tick();
        check_val("wait_still_ready0", 32'(br_ready), 32'd0);
        N_en = 1; N_set = 1; tick(); clear_flags_wr();
        check_val("wait_resolved", 32'(res_valid), 32'd1);
        check_val("wait_back_idle", 32'(br_ready), 32'd1);
        N = 1; tick(); N = 0;

        // Saturation: 3 issues fill, a 4th is ignored, writes drain.
        for (int i = 0; i < 3; i++) begin
            fs_issue = 1; tick();
        end
        check_val("full_after3", 32'(fs_full), 32'd1);
        tick(); fs_issue = 0;
        check_val("full_after4", 32'(fs_full), 32'd1);
        V_en = 1; V_set = 0; tick();
        check_val("full_after_w1", 32'(fs_full), 32'd0);
        tick(); clear_flags_wr();
        Z_en = 1; Z_set = 0;
        drive_branch(3'b000, 0, 16'h0400, 9'h1FE, 16'h0, 1, 1);
        clear_flags_wr();
        check_val("drain_resolve", 32'(res_valid), 32'd1);

        // Issue and write in the same cycle with pend=1: still waiting.
        fs_issue = 1; tick(); fs_issue = 0;
        drive_branch(3'b001, 1, 16'h0500, 9'd0, 16'hBEEF, 1, 1);
        fs_issue = 1; Z_en = 1; Z_set = 0; tick(); fs_issue = 0; clear_flags_wr();
        check_val("both_no_valid", 32'(res_valid), 32'd0);
        check_val("both_br_ready", 32'(br_ready), 32'd0);
        Z_en = 1; Z_set = 1; tick(); clear_flags_wr();
        check_val("both_resolved", 32'(res_valid), 32'd1);
        Z = 1; tick(); Z = 0;

        // Negative offset wrap.
        drive_branch(3'b111, 0, 16'h0100, 9'h100, 16'h0, 1, 1);
        check_val("wrap_target_direct", 32'(res_target), 32'hFF00);

        // Reset while waiting drops the branch.
        fs_issue = 1; tick(); fs_issue = 0;
        drive_branch(3'b001, 0, 16'h0600, 9'd2, 16'h0, 0, 0);
        check_val("rstw_waiting", 32'(br_ready), 32'd0);
        rst = 1; tick(); rst = 0;
        check_val("rstw_no_valid", 32'(res_valid), 32'd0);
        check_val("rstw_br_ready", 32'(br_ready), 32'd1);
        check_val("rstw_fs_full", 32'(fs_full), 32'd0);
        tick(); tick();
        check_val("rstw_still_no_valid", 32'(res_valid), 32'd0);

        // Post-reset sanity: pend cleared, so EQ with Z=1 resolves immediately.
        Z = 1;
        drive_branch(3'b001, 0, 16'h0700, 9'd3, 16'h0, 1, 1);
        check_val("post_rst_resolve", 32'(res_valid), 32'd1);
        tick(); tick();

        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
